// File: rtl/gcd_axil_engine_if.sv
// AXI4-Lite slave bus bundle for gcd_axil_engine.
// Signals keep their AXI names (S_AXI_*): AW/W/B write channels, AR/R read channel.
// Modports: slave (the engine), master (the bus driver / testbench).
interface gcd_axil_engine_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic [2:0]          S_AXI_AWPROT;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic [2:0]          S_AXI_ARPROT;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/gcd_axil_engine.sv
// AXI4-Lite GCD accelerator: subtractive Euclid, one step per clock.
// Register map (byte addr): 0x00 OPA rw, 0x04 OPB rw, 0x08 CTRL w, 0x0C STATUS r,
//   0x10 RESULT r, 0x14 CYCLES r; other addresses read 0, writes ignored.
// Ports:
//   S_AXI_ACLK     clock
//   S_AXI_ARESETN  asynchronous active-low reset
//   s_axi          gcd_axil_engine_if.slave (AW/W/B/AR/R channels)
//   irq            level interrupt DONE & IE, only when GCD_IRQ_EN is defined
// Optional feature macro: GCD_IRQ_EN (irq port and CTRL/STATUS IE bit).
module gcd_axil_engine #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
  parameter int unsigned OPW                = 32,
  parameter int unsigned CNTW               = 16
) (
  input  logic             S_AXI_ACLK,
  input  logic             S_AXI_ARESETN,
  gcd_axil_engine_if.slave s_axi
`ifdef GCD_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;

  localparam logic [2:0] A_OPA    = 3'd0;
  localparam logic [2:0] A_OPB    = 3'd1;
  localparam logic [2:0] A_CTRL   = 3'd2;
  localparam logic [2:0] A_STATUS = 3'd3;
  localparam logic [2:0] A_RESULT = 3'd4;
  localparam logic [2:0] A_CYCLES = 3'd5;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_DONE} state_t;

  state_t            r_state;
  logic [OPW-1:0]    r_opa, r_opb, r_a, r_b, r_result;
  logic [CNTW-1:0]   r_cycles;
  logic              r_busy, r_done, r_err;
  logic              r_awready, r_bvalid, r_arready, r_rvalid;
  logic [DW-1:0]     r_rdata;
`ifdef GCD_IRQ_EN
  logic              r_ie, r_irq;
`endif

  logic              w_wr_fire, w_rd_fire, w_ctrl_wr, w_start, w_clr, w_ie;
  logic [2:0]        w_waddr, w_raddr;
  logic [DW-1:0]     w_rdata;
  logic              w_unused_ok;

  // Byte-strobe merge of a write into an OPW-wide register; bytes above OPW drop out.
  function automatic logic [OPW-1:0] merge_strb(input logic [OPW-1:0] old,
                                                input logic [DW-1:0] wd,
                                                input logic [DW/8-1:0] st);
    logic [DW-1:0] m;
    m = DW'(old);
    for (int i = 0; i < int'(DW/8); i++) begin
      if (st[i]) m[8*i +: 8] = wd[8*i +: 8];
    end
    return m[OPW-1:0];
  endfunction

  assign w_waddr   = s_axi.S_AXI_AWADDR[4:2];
  assign w_raddr   = s_axi.S_AXI_ARADDR[4:2];
  assign w_wr_fire = r_awready & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
  assign w_rd_fire = r_arready & s_axi.S_AXI_ARVALID;
  assign w_ctrl_wr = w_wr_fire && (w_waddr == A_CTRL) && s_axi.S_AXI_WSTRB[0];
  assign w_start   = w_ctrl_wr & s_axi.S_AXI_WDATA[0];
  assign w_clr     = w_ctrl_wr & s_axi.S_AXI_WDATA[1];
`ifdef GCD_IRQ_EN
  assign w_ie      = r_ie;
  assign irq       = r_irq;
`else
  assign w_ie      = 1'b0;
`endif

  assign w_unused_ok = ^{s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0],
                         s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, AW[0]};

  assign s_axi.S_AXI_AWREADY = r_awready;
  assign s_axi.S_AXI_WREADY  = r_awready;
  assign s_axi.S_AXI_BVALID  = r_bvalid;
  assign s_axi.S_AXI_BRESP   = 2'b00;
  assign s_axi.S_AXI_ARREADY = r_arready;
  assign s_axi.S_AXI_RVALID  = r_rvalid;
  assign s_axi.S_AXI_RDATA   = r_rdata;
  assign s_axi.S_AXI_RRESP   = 2'b00;

  // Write channel: ready pulses one cycle once both AW and W are valid and no response is pending.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      r_awready <= s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID && !r_bvalid && !r_awready;
      if (w_wr_fire)                r_bvalid <= 1'b1;
      else if (s_axi.S_AXI_BREADY)  r_bvalid <= 1'b0;
    end
  end

  // Read data mux, sampled into r_rdata at the AR handshake.
  always_comb begin
    w_rdata = '0;
    case (w_raddr)
      A_OPA:    w_rdata = DW'(r_opa);
      A_OPB:    w_rdata = DW'(r_opb);
      A_STATUS: w_rdata = DW'({w_ie, r_err, r_done, r_busy});
      A_RESULT: w_rdata = DW'(r_result);
      A_CYCLES: w_rdata = DW'(r_cycles);
      default:  w_rdata = '0;
    endcase
  end

  // Read channel: one read outstanding, data held until RREADY.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_arready <= s_axi.S_AXI_ARVALID && !r_rvalid && !r_arready;
      if (w_rd_fire) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rdata;
      end else if (s_axi.S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // Register file and GCD engine FSM.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state  <= ST_IDLE;
      r_opa    <= '0;
      r_opb    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_cycles <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
`ifdef GCD_IRQ_EN
      r_ie     <= 1'b0;
      r_irq    <= 1'b0;
`endif
    end else begin
      if (w_wr_fire && (w_waddr == A_OPA))
        r_opa <= merge_strb(r_opa, s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);
      if (w_wr_fire && (w_waddr == A_OPB))
        r_opb <= merge_strb(r_opb, s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);
`ifdef GCD_IRQ_EN
      if (w_ctrl_wr) r_ie <= s_axi.S_AXI_WDATA[2];
      r_irq <= r_done & r_ie;
`endif
      // Later assignments in the FSM (DONE set, START clear) take priority over DONE_CLR.
      if (w_clr) r_done <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_LOAD;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
          end
        end
        ST_LOAD: begin
          r_a      <= r_opa;
          r_b      <= r_opb;
          r_cycles <= '0;
          r_state  <= ST_RUN;
        end
        ST_RUN: begin
          if (r_cycles != '1) r_cycles <= r_cycles + CNTW'(1);
          if ((r_a == r_b) || (r_a == '0) || (r_b == '0)) begin
            // Final value parked in r_a; OR picks the non-zero operand when one is zero.
            r_a     <= (r_a == r_b) ? r_a : (r_a | r_b);
            r_state <= ST_DONE;
          end else if (r_a > r_b) begin
            r_a <= r_a - r_b;
          end else begin
            r_b <= r_b - r_a;
          end
        end
        ST_DONE: begin
          r_result <= r_a;
          r_done   <= 1'b1;
          r_err    <= (r_a == '0);
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_axil_engine.sv
// Scoreboard bench for gcd_axil_engine (OPW=8 instance): read expectations are queued
// at issue time and checked by a monitor on each R beat; B beats are checked for OKAY.
module tb_gcd_axil_engine;

  localparam logic [4:0] OPA = 5'h00, OPB = 5'h04, CTRL = 5'h08,
                         STAT = 5'h0C, RES = 5'h10, CYC = 5'h14;
  localparam int unsigned TMO = 50;
`ifdef GCD_IRQ_EN
  localparam logic [31:0] IEB = 32'h8;
`else
  localparam logic [31:0] IEB = 32'h0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gcd_axil_engine_if #(.ADDR_W(5), .DATA_W(32)) bus ();
`ifdef GCD_IRQ_EN
  logic irq;
`endif

  gcd_axil_engine #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5), .OPW(8), .CNTW(16)) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rst_n),
    .s_axi        (bus)
`ifdef GCD_IRQ_EN
    ,
    .irq          (irq)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: no handshake within %0d cycles", nm, TMO);
  endtask

  // Drive point: 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: checks every completed R and B beat on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.S_AXI_RVALID && bus.S_AXI_RREADY) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_rbeat: got data 0x%08h, expected no beat", bus.S_AXI_RDATA);
        end else begin
          check(name_q.pop_front(), bus.S_AXI_RDATA, exp_q.pop_front());
          check("rresp", 32'(bus.S_AXI_RRESP), 32'h0);
        end
      end
      if (rst_n && bus.S_AXI_BVALID && bus.S_AXI_BREADY)
        check("bresp", 32'(bus.S_AXI_BRESP), 32'h0);
    end
  end

  task automatic wait_aw();
    int t = 0;
    while (!bus.S_AXI_AWREADY && t < TMO) begin tick(); t++; end
    if (t >= TMO) timeout("awready");
  endtask

  task automatic wait_ar();
    int t = 0;
    while (!bus.S_AXI_ARREADY && t < TMO) begin tick(); t++; end
    if (t >= TMO) timeout("arready");
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    int t = 0;
    tick();
    bus.S_AXI_AWADDR = a; bus.S_AXI_WDATA = d; bus.S_AXI_WSTRB = s;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_BREADY = 1'b1;
    wait_aw();
    tick();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    while (!bus.S_AXI_BVALID && t < TMO) begin tick(); t++; end
    if (t >= TMO) timeout("bvalid");
    tick();
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string nm);
    int t = 0;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    tick();
    bus.S_AXI_ARADDR = a; bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_RREADY = 1'b1;
    wait_ar();
    tick();
    bus.S_AXI_ARVALID = 1'b0;
    while (!bus.S_AXI_RVALID && t < TMO) begin tick(); t++; end
    if (t >= TMO) timeout("rvalid");
    tick();
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int wait_cyc);
    wr(OPA, a);
    wr(OPB, b);
    wr(CTRL, 32'h1);
    repeat (wait_cyc) tick();
  endtask

  initial begin
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = '0;  bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;

    // Reset values
    repeat (3) tick();
    check("rst_awready", 32'(bus.S_AXI_AWREADY), 32'h0);
    check("rst_wready",  32'(bus.S_AXI_WREADY),  32'h0);
    check("rst_bvalid",  32'(bus.S_AXI_BVALID),  32'h0);
    check("rst_arready", 32'(bus.S_AXI_ARREADY), 32'h0);
    check("rst_rvalid",  32'(bus.S_AXI_RVALID),  32'h0);
    check("rst_rdata",   bus.S_AXI_RDATA,        32'h0);
`ifdef GCD_IRQ_EN
    check("rst_irq", 32'(irq), 32'h0);
`endif
    rst_n = 1'b1;
    tick();
    rd(STAT, 32'h0, "status_after_reset");

    // 48/18: BUSY seen, then GCD 6 in 5 RUN cycles
    wr(OPA, 32'd48);
    wr(OPB, 32'd18);
    rd(OPA, 32'd48, "opa_rb");
    rd(OPB, 32'd18, "opb_rb");
    wr(CTRL, 32'h1);
    rd(STAT, 32'h1, "status_busy");
    repeat (20) tick();
    rd(STAT, 32'h2, "status_done_48_18");
    rd(RES,  32'd6, "result_48_18");
    rd(CYC,  32'd5, "cycles_48_18");

    // One operand zero
    run_op(32'd0, 32'd7, 20);
    rd(RES,  32'd7, "result_0_7");
    rd(CYC,  32'd1, "cycles_0_7");
    rd(STAT, 32'h2, "status_0_7");

    // Both zero: ERR
    run_op(32'd0, 32'd0, 20);
    rd(RES,  32'd0, "result_0_0");
    rd(STAT, 32'h6, "status_err");

    // Operand truncated to OPW=8 bits
    wr(OPA, 32'h1F0);
    rd(OPA, 32'hF0, "opa_trunc");
    wr(OPB, 32'h0C);
    wr(CTRL, 32'h1);
    repeat (40) tick();
    rd(RES,  32'd12, "result_f0_0c");
    rd(CYC,  32'd20, "cycles_f0_0c");
    rd(STAT, 32'h2, "status_f0_0c");

    // Byte strobes
    wr(OPA, 32'hAB, 4'h0);
    rd(OPA, 32'hF0, "opa_strb0");
    wr(OPA, 32'h5500, 4'h2);
    rd(OPA, 32'hF0, "opa_strb_hi");
    wr(OPA, 32'h33, 4'h1);
    rd(OPA, 32'h33, "opa_strb_lo");
    wr(CTRL, 32'h1, 4'h0);
    repeat (5) tick();
    rd(CYC,  32'd20, "ctrl_nostrobe_cycles");
    rd(STAT, 32'h2, "ctrl_nostrobe_status");

    // START while BUSY ignored; OPA rewrite mid-run not seen by running op
    wr(OPA, 32'd200);
    wr(OPB, 32'd2);
    wr(CTRL, 32'h1);
    wr(OPA, 32'd9);
    wr(CTRL, 32'h1);
    repeat (150) tick();
    rd(RES, 32'd2,   "result_midrun");
    rd(CYC, 32'd100, "cycles_midrun");
    rd(OPA, 32'd9,   "opa_midrun_rb");
    wr(CTRL, 32'h1);
    repeat (20) tick();
    rd(RES, 32'd1, "result_new_opa");
    rd(CYC, 32'd6, "cycles_new_opa");

    // DONE_CLR
    wr(CTRL, 32'h2);
    rd(STAT, 32'h0, "status_doneclr");

    // IE and irq
    wr(CTRL, 32'h4);
    rd(STAT, IEB, "status_ie");
    wr(OPA, 32'd48);
    wr(OPB, 32'd18);
    wr(CTRL, 32'h5);
    repeat (20) tick();
    rd(STAT, IEB | 32'h2, "status_ie_done");
`ifdef GCD_IRQ_EN
    check("irq_set", 32'(irq), 32'h1);
`endif
    wr(CTRL, 32'h6);
    tick();
    rd(STAT, IEB, "status_ie_clr");
`ifdef GCD_IRQ_EN
    check("irq_clr", 32'(irq), 32'h0);
`endif

    // Write back-pressure: BVALID held, no second accept while BREADY low
    tick();
    bus.S_AXI_AWADDR = OPA; bus.S_AXI_WDATA = 32'h11; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_BREADY = 1'b0;
    wait_aw();
    tick();
    bus.S_AXI_AWADDR = OPB; bus.S_AXI_WDATA = 32'h22;
    for (int i = 0; i < 10; i++) begin
      check("bp_bvalid_held", 32'(bus.S_AXI_BVALID), 32'h1);
      check("bp_no_awready",  32'(bus.S_AXI_AWREADY), 32'h0);
      tick();
    end
    bus.S_AXI_BREADY = 1'b1;
    wait_aw();
    tick();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    repeat (3) tick();

    // Read back-pressure: RVALID/RDATA held, no second accept while RREADY low
    exp_q.push_back(32'h11); name_q.push_back("bp_read_opa");
    exp_q.push_back(32'h22); name_q.push_back("bp_read_opb");
    bus.S_AXI_ARADDR = OPA; bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_RREADY = 1'b0;
    wait_ar();
    tick();
    bus.S_AXI_ARADDR = OPB;
    for (int i = 0; i < 10; i++) begin
      check("bp_rvalid_held", 32'(bus.S_AXI_RVALID), 32'h1);
      check("bp_rdata_held",  bus.S_AXI_RDATA,       32'h11);
      check("bp_no_arready",  32'(bus.S_AXI_ARREADY), 32'h0);
      tick();
    end
    bus.S_AXI_RREADY = 1'b1;
    wait_ar();
    tick();
    bus.S_AXI_ARVALID = 1'b0;
    repeat (3) tick();

    // Reset in the middle of a run
    run_op(32'd200, 32'd2, 10);
    rst_n = 1'b0;
    #2;
    check("midrst_awready", 32'(bus.S_AXI_AWREADY), 32'h0);
    check("midrst_bvalid",  32'(bus.S_AXI_BVALID),  32'h0);
    check("midrst_rvalid",  32'(bus.S_AXI_RVALID),  32'h0);
    check("midrst_rdata",   bus.S_AXI_RDATA,        32'h0);
`ifdef GCD_IRQ_EN
    check("midrst_irq", 32'(irq), 32'h0);
`endif
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    rd(STAT, 32'h0, "midrst_status");
    rd(RES,  32'h0, "midrst_result");
    rd(CYC,  32'h0, "midrst_cycles");
    rd(OPA,  32'h0, "midrst_opa");
    repeat (3) tick();

    // Drain scoreboard
    for (int t = 0; t < int'(TMO) && exp_q.size() != 0; t++) tick();
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d pending reads, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
